rtc_lectura_secuencial: RTL
===========================

Name: rtc_lectura_secuencial

Overview:
- Read-side sequencer for the RTC bus controller, the counterpart to the user write machine.
- On a start request it issues one bus read per RTC time/timer register: 0x21–0x26 (seconds, minutes, hours, day, month, year) and 0x41–0x43 (timer seconds, minutes, hours).
- Each returned byte is copied into the local BCD register bank at index 1..9.
- Sits between the bus controller (lee/dir_out/fin/dato_in) and the display register bank (addr/dato_out/escribe).

Parameters:
- NUM_REGS, 9, number of registers swept; valid range 1..9, indices 1..NUM_REGS.
- TIMEOUT_CYCLES, 255, max cycles to wait for fin per bus transaction before aborting; 8-bit counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- iniciar  input  1  start request; sampled only in IDLE
- fin  input  1  bus controller transaction-complete pulse
- dato_in  input  8  read data from bus controller; valid in the cycle fin=1
- lee  output  1  bus read request; held high until fin
- escribe_rtc  output  1  bus write request (used only by the optional transfer command)
- dir_out  output  8  RTC bus address
- addr  output  4  register-bank index
- dato_out  output  8  register-bank write data
- escribe  output  1  register-bank write strobe, one cycle
- ocupado  output  1  high whenever state != IDLE
- final  output  1  one-cycle pulse on successful sweep end
- error  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0; index = 1; timeout counter = 0; state = IDLE. Reset wins over every other input, including mid-sweep.
- IDLE: iniciar=1 moves to XFER when RTC_XFER_CMD_EN is defined, else to REQ.
- REQ: drive lee=1 and dir_out=map(index). The next cycle moves to WAIT with lee still held.
- Address map: 1→0x21, 2→0x22, 3→0x23, 4→0x24, 5→0x25, 6→0x26, 7→0x41, 8→0x42, 9→0x43; any other index→0x00.
- WAIT: lee=1 and dir_out held stable.
  - fin=1: latch dato_in, drop lee, clear the counter, go to STORE.
  - Counter reaches TIMEOUT_CYCLES with fin=0: go to ABORT.
  - fin and timeout in the same cycle: fin wins.
- STORE: addr=index, dato_out=latched byte, escribe=1 for exactly one cycle. The byte is passed through unmodified; no BCD correction.
- NEXT: escribe=0.
  - index==NUM_REGS: go to DONE.
  - Otherwise index+1, go to REQ.
- DONE: final=1 for one cycle, index=1, all bus outputs 0, return to IDLE.
- ABORT: error=1 for one cycle, lee=0, index=1, return to IDLE. Bank writes already done are kept.
- iniciar is ignored outside IDLE. iniciar held high restarts a sweep in the cycle after DONE/ABORT reaches IDLE.
- fin pulses outside WAIT/XFER_WAIT are ignored.
- Latency: each register takes 4 cycles plus the fin wait (REQ, WAIT≥1, STORE, NEXT).

Optional Feature:
- Macro: RTC_XFER_CMD_EN.
- Defined: before the sweep, XFER drives escribe_rtc=1 and dir_out=0xF0 (the RTC "transfer to read buffer" command). XFER_WAIT holds these until fin, then goes to REQ. Timeout applies here too, leading to ABORT.
- Not defined: XFER/XFER_WAIT are absent and escribe_rtc is tied to 0.

Decomposition:
- Shared package rtc_pkg holds:
  - state encoding (IDLE, XFER, XFER_WAIT, REQ, WAIT, STORE, NEXT, DONE, ABORT);
  - RTC address constants 0x21–0x26, 0x41–0x43, 0xF0;
  - the BCD top constants shared with the write machine.
- One combinational sub-module, rtc_mapa_direcciones, maps index→RTC address.

Test Plan:
- Model answers fin after 3 cycles with dato_in = 0x10+index; pulse iniciar → escribe at addr 1..9 with data 0x11..0x19, dir_out sequence 0x21..0x26, 0x41..0x43, single final pulse, ocupado low afterwards.
- Model never asserts fin on index 4 → exactly 255 WAIT cycles, then error pulse; only addr 1..3 written; ocupado drops next cycle.
- Assert reset during WAIT of index 6 → next cycle all outputs 0, state IDLE; a new iniciar restarts at dir_out 0x21.
- fin and timeout in the same cycle, and fin pulses injected in REQ/STORE → data is captured and no error; stray pulses are ignored.
- NUM_REGS=6 → only 0x21..0x26 read; final follows the index-6 store.
- RTC_XFER_CMD_EN defined → escribe_rtc with dir_out 0xF0 precedes the first lee; without the macro, escribe_rtc stays 0 throughout.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer and the user write machine:
// FSM state encoding, RTC bus addresses and BCD register top values.
package rtc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        XFER,
        XFER_WAIT,
        REQ,
        WAIT,
        STORE,
        NEXT,
        DONE,
        ABORT
    } estado_t;

    localparam logic [7:0] DIR_SEG      = 8'h21;
    localparam logic [7:0] DIR_MIN      = 8'h22;
    localparam logic [7:0] DIR_HORA     = 8'h23;
    localparam logic [7:0] DIR_DIA      = 8'h24;
    localparam logic [7:0] DIR_MES      = 8'h25;
    localparam logic [7:0] DIR_ANIO     = 8'h26;
    localparam logic [7:0] DIR_TMR_SEG  = 8'h41;
    localparam logic [7:0] DIR_TMR_MIN  = 8'h42;
    localparam logic [7:0] DIR_TMR_HORA = 8'h43;
    localparam logic [7:0] DIR_XFER     = 8'hF0;
    localparam logic [7:0] DIR_NULA     = 8'h00;

    // Highest legal BCD value of each field, shared with the write machine.
    localparam logic [7:0] BCD_TOPE_SEG  = 8'h59;
    localparam logic [7:0] BCD_TOPE_MIN  = 8'h59;
    localparam logic [7:0] BCD_TOPE_HORA = 8'h23;
    localparam logic [7:0] BCD_TOPE_DIA  = 8'h31;
    localparam logic [7:0] BCD_TOPE_MES  = 8'h12;
    localparam logic [7:0] BCD_TOPE_ANIO = 8'h99;

endpackage

// File: rtl/rtc_mapa_direcciones.sv
// Combinational map from register-bank index (1..9) to RTC bus address.
module rtc_mapa_direcciones
    import rtc_pkg::*;
(
    input  logic [3:0] indice,
    output logic [7:0] dir
);

    always_comb begin
        // NOTE: default assignment first so every path drives dir and no latch is inferred.
        dir = DIR_NULA;
        case (indice)
            4'd1:    dir = DIR_SEG;
            4'd2:    dir = DIR_MIN;
            4'd3:    dir = DIR_HORA;
            4'd4:    dir = DIR_DIA;
            4'd5:    dir = DIR_MES;
            4'd6:    dir = DIR_ANIO;
            4'd7:    dir = DIR_TMR_SEG;
            4'd8:    dir = DIR_TMR_MIN;
            4'd9:    dir = DIR_TMR_HORA;
            default: dir = DIR_NULA;
        endcase
    end

endmodule

// File: rtl/rtc_lectura_secuencial.sv
// RTC read sequencer: sweeps 0x21-0x26 and 0x41-0x43 into the BCD register bank.
// Define RTC_XFER_CMD_EN to issue the 0xF0 transfer command before every sweep.
module rtc_lectura_secuencial
    import rtc_pkg::*;
#(
    parameter int NUM_REGS       = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fin,
    input  logic [7:0] dato_in,
    output logic       lee,
    output logic       escribe_rtc,
    output logic [7:0] dir_out,
    output logic [3:0] addr,
    output logic [7:0] dato_out,
    output logic       escribe,
    output logic       ocupado,
    output logic       finalizado,
    output logic       error
);

    localparam logic [3:0] ULTIMO      = 4'(NUM_REGS);
    localparam logic [7:0] TOPE_ESPERA = 8'(TIMEOUT_CYCLES - 1);

    estado_t    estado;
    logic [3:0] indice;
    logic [7:0] contador;
    logic [3:0] indice_map;
    logic [7:0] dir_map;

    // The REQ address is registered while leaving NEXT, so look one index ahead there.
    assign indice_map = (estado == NEXT) ? indice + 4'd1 : indice;

    rtc_mapa_direcciones u_mapa (
        .indice (indice_map),
        .dir    (dir_map)
    );

    assign ocupado = (estado != IDLE);

`ifdef RTC_XFER_CMD_EN
    logic escribe_rtc_q;
    assign escribe_rtc = escribe_rtc_q;
`else
    assign escribe_rtc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= IDLE;
            indice     <= 4'd1;
            contador   <= '0;
            lee        <= 1'b0;
            dir_out    <= '0;
            addr       <= '0;
            dato_out   <= '0;
            escribe    <= 1'b0;
            finalizado <= 1'b0;
            error      <= 1'b0;
`ifdef RTC_XFER_CMD_EN
            escribe_rtc_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (estado)
                IDLE: begin
                    if (iniciar) begin
`ifdef RTC_XFER_CMD_EN
                        estado        <= XFER;
                        escribe_rtc_q <= 1'b1;
                        dir_out       <= DIR_XFER;
                        contador      <= '0;
`else
                        estado  <= REQ;
                        lee     <= 1'b1;
                        dir_out <= dir_map;
`endif
                    end
                end
`ifdef RTC_XFER_CMD_EN
                XFER: estado <= XFER_WAIT;
                XFER_WAIT: begin
                    if (fin) begin
                        escribe_rtc_q <= 1'b0;
                        lee           <= 1'b1;
                        dir_out       <= dir_map;
                        contador      <= '0;
                        estado        <= REQ;
                    end else if (contador == TOPE_ESPERA) begin
                        escribe_rtc_q <= 1'b0;
                        dir_out       <= '0;
                        error         <= 1'b1;
                        contador      <= '0;
                        estado        <= ABORT;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
`endif
                REQ: begin
                    contador <= '0;
                    estado   <= WAIT;
                end
                WAIT: begin
                    // fin is tested first so a reply on the last allowed cycle still counts.
                    if (fin) begin
                        lee      <= 1'b0;
                        dir_out  <= '0;
                        addr     <= indice;
                        dato_out <= dato_in;
                        escribe  <= 1'b1;
                        contador <= '0;
                        estado   <= STORE;
                    end else if (contador == TOPE_ESPERA) begin
                        lee      <= 1'b0;
                        dir_out  <= '0;
                        error    <= 1'b1;
                        contador <= '0;
                        estado   <= ABORT;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end
                STORE: begin
                    escribe <= 1'b0;
                    estado  <= NEXT;
                end
                NEXT: begin
                    if (indice == ULTIMO) begin
                        finalizado <= 1'b1;
                        lee        <= 1'b0;
                        dir_out    <= '0;
                        estado     <= DONE;
                    end else begin
                        indice  <= indice + 4'd1;
                        lee     <= 1'b1;
                        dir_out <= dir_map;
                        estado  <= REQ;
                    end
                end
                DONE: begin
                    finalizado <= 1'b0;
                    indice     <= 4'd1;
                    estado     <= IDLE;
                end
                ABORT: begin
                    error  <= 1'b0;
                    indice <= 4'd1;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule
